// File: rtl/skill_scheduler_pkg.sv
// Shared constants and helpers for the skill scheduler: skill indices,
// default timing parameters and the round-robin selector.
package skill_scheduler_pkg;

    localparam int NUM_SKILLS         = 3;
    localparam int SKILL_J            = 2;
    localparam int SKILL_K            = 1;
    localparam int SKILL_L            = 0;

    localparam int DEF_MAX_POINTS     = 3;
    localparam int DEF_REFILL_TICKS   = 200;
    localparam int DEF_DURATION_TICKS = 100;

    typedef logic [NUM_SKILLS-1:0] skill_vec_t;
    typedef logic [1:0]            skill_idx_t;

    // First eligible index strictly after 'last', wrapping around to 'last' itself.
    function automatic skill_vec_t rr_pick(input skill_vec_t elig, input skill_idx_t last);
        skill_vec_t pick;
        int         idx;
        pick = '0;
        for (int k = 1; k <= NUM_SKILLS; k++) begin
            idx = (int'(last) + k) % NUM_SKILLS;
            if (pick == '0 && elig[idx]) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic skill_idx_t onehot_to_idx(input skill_vec_t v);
        skill_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_SKILLS; i++) begin
            if (v[i]) begin
                idx = skill_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/skill_scheduler_timer.sv
// Per-skill duration down-counter; 'active' rises with the load and falls
// one cycle after the count has reached zero.
module skill_timer
    import skill_scheduler_pkg::*;
#(
    parameter int DURATION_TICKS = DEF_DURATION_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic tick,
    output logic active
);

    localparam int CW = $clog2(DURATION_TICKS + 1);

    logic [CW-1:0] count_q, count_d;
    logic          active_q, active_d;

    always_comb begin
        count_d  = count_q;
        active_d = load | (count_q != '0);
        if (clr) begin
            count_d  = '0;
            active_d = 1'b0;
        end else if (load) begin
            // A load wins over a coincident tick, so the full duration is kept.
            count_d = CW'(DURATION_TICKS);
        end else if (tick && count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/skill_scheduler.sv
// Skill-request arbiter: round-robin grant of one skill per cycle, gated by
// skill points that refill on a tick-driven timer.
module skill_scheduler
    import skill_scheduler_pkg::*;
#(
    parameter int REFILL_TICKS   = DEF_REFILL_TICKS,
    parameter int DURATION_TICKS = DEF_DURATION_TICKS,
    parameter int MAX_POINTS     = DEF_MAX_POINTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       enable,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [2:0] active,
    output logic [1:0] points
);

    localparam int         RW    = (REFILL_TICKS > 1) ? $clog2(REFILL_TICKS) : 1;
    localparam logic [2:0] MAX_P = 3'(MAX_POINTS);

    logic [RW-1:0] refill_q, refill_d;
    logic [1:0]    points_q, points_d;
    skill_idx_t    last_q, last_d;
    skill_vec_t    grant_q, grant_d;

    skill_vec_t    elig;
    skill_vec_t    pick;
    logic          wrap;
    logic [2:0]    pts_sum;

    always_comb begin
        // Registered points gate eligibility, so a same-cycle refill cannot grant from zero.
        elig     = req & ~active & {NUM_SKILLS{points_q != 2'd0}} & {NUM_SKILLS{enable}};
        pick     = rr_pick(elig, last_q);
        wrap     = enable & tick & (refill_q == RW'(REFILL_TICKS - 1));

        refill_d = refill_q;
        if (enable && tick) begin
            refill_d = wrap ? '0 : refill_q + RW'(1);
        end

        pts_sum  = {1'b0, points_q} - {2'b00, (pick != '0)} + {2'b00, wrap};
        points_d = (pts_sum > MAX_P) ? MAX_P[1:0] : pts_sum[1:0];
        last_d   = (pick != '0) ? onehot_to_idx(pick) : last_q;
        grant_d  = pick;

        if (!enable) begin
            refill_d = '0;
            points_d = '0;
            last_d   = '0;
            grant_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refill_q <= '0;
            points_q <= '0;
            last_q   <= '0;
            grant_q  <= '0;
        end else begin
            refill_q <= refill_d;
            points_q <= points_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SKILLS; gi++) begin : g_timer
            skill_timer #(
                .DURATION_TICKS(DURATION_TICKS)
            ) u_timer (
                .clk   (clk),
                .rst   (rst),
                .clr   (~enable),
                .load  (pick[gi]),
                .tick  (tick),
                .active(active[gi])
            );
        end
    endgenerate

    assign grant  = grant_q;
    assign points = points_q;

endmodule

// File: tb/tb_skill_scheduler.sv
// Bench for skill_scheduler: directed table, refill sequences and randomized
// traffic checked against a cycle-level behavioural model.
module tb_skill_scheduler;
    import skill_scheduler_pkg::*;

    localparam int R  = 4;
    localparam int D  = 3;
    localparam int MP = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       enable;
    logic [2:0] req;
    logic [2:0] grant;
    logic [2:0] active;
    logic [1:0] points;

    always #5 clk = ~clk;

    skill_scheduler #(
        .REFILL_TICKS  (R),
        .DURATION_TICKS(D),
        .MAX_POINTS    (MP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .enable(enable),
        .req   (req),
        .grant (grant),
        .active(active),
        .points(points)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_rem[3];
    bit         m_act[3];
    int         m_points;
    int         m_refill;
    int         m_last;
    logic [2:0] m_grant;

    typedef struct {
        bit         r;
        bit         e;
        bit         t;
        logic [2:0] q;
        logic [2:0] eg;
        logic [2:0] ea;
        int         ep;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] m_act_vec();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = m_act[i];
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit t, input logic [2:0] q);
        int sel;
        int p;
        if (r || !e) begin
            for (int i = 0; i < 3; i++) begin
                m_rem[i] = 0;
                m_act[i] = 0;
            end
            m_points = 0;
            m_refill = 0;
            m_last   = 0;
            m_grant  = 3'b000;
            return;
        end
        sel = -1;
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_last + k) % 3;
            if (sel < 0 && q[idx] && !m_act[idx] && m_points > 0) sel = idx;
        end
        m_grant = 3'b000;
        if (sel >= 0) begin
            m_grant[sel] = 1'b1;
            m_last       = sel;
        end
        for (int i = 0; i < 3; i++) begin
            if (i == sel) begin
                m_act[i] = 1;
                m_rem[i] = D;
            end else begin
                m_act[i] = (m_rem[i] > 0);
                if (t && m_rem[i] > 0) m_rem[i]--;
            end
        end
        p = m_points - ((sel >= 0) ? 1 : 0);
        if (t) begin
            if (m_refill == R - 1) begin
                m_refill = 0;
                p++;
            end else begin
                m_refill++;
            end
        end
        if (p > MP) p = MP;
        m_points = p;
    endtask

    task automatic step(input bit r, input bit e, input bit t, input logic [2:0] q, input string tag);
        rst    = r;
        enable = e;
        tick   = t;
        req    = q;
        @(posedge clk);
        model_edge(r, e, t, q);
        #1;
        chk({tag, " grant"},  int'(grant),  int'(m_grant));
        chk({tag, " active"}, int'(active), int'(m_act_vec()));
        chk({tag, " points"}, int'(points), m_points);
        $display("%0t %s: rst=%0b en=%0b tick=%0b req=%03b -> grant=%03b active=%03b points=%0d",
                 $time, tag, r, e, t, q, grant, active, points);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        tick   = 1'b0;
        req    = 3'b000;

        step(1, 0, 0, 3'b000, "reset");
        step(1, 1, 1, 3'b111, "reset");
        chk("reset grant",  int'(grant),  0);
        chk("reset active", int'(active), 0);
        chk("reset points", int'(points), 0);

        // Refill: one point per R ticks, saturating at MP.
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 1, 3'b000, "refill");
            if (k % 4 == 0) chk("refill points", int'(points), (k / 4 > MP) ? MP : k / 4);
            step(0, 1, 0, 3'b000, "refill");
        end

        // Directed table: starts at points=3, refill=0, pointer=0.
        tbl[0]  = '{0, 1, 0, 3'b100, 3'b100, 3'b100, 2};
        tbl[1]  = '{0, 1, 1, 3'b000, 3'b000, 3'b100, 2};
        tbl[2]  = '{0, 1, 0, 3'b000, 3'b000, 3'b100, 2};
        tbl[3]  = '{0, 1, 1, 3'b000, 3'b000, 3'b100, 2};
        tbl[4]  = '{0, 1, 1, 3'b000, 3'b000, 3'b100, 2};
        tbl[5]  = '{0, 1, 0, 3'b000, 3'b000, 3'b000, 2};
        tbl[6]  = '{0, 1, 1, 3'b001, 3'b001, 3'b001, 2};
        tbl[7]  = '{0, 1, 0, 3'b001, 3'b000, 3'b001, 2};
        tbl[8]  = '{0, 1, 0, 3'b110, 3'b010, 3'b011, 1};
        tbl[9]  = '{0, 1, 0, 3'b100, 3'b100, 3'b111, 0};
        tbl[10] = '{0, 0, 1, 3'b111, 3'b000, 3'b000, 0};
        tbl[11] = '{0, 1, 1, 3'b000, 3'b000, 3'b000, 0};
        tbl[12] = '{0, 1, 1, 3'b000, 3'b000, 3'b000, 0};
        tbl[13] = '{0, 1, 1, 3'b000, 3'b000, 3'b000, 0};
        tbl[14] = '{0, 1, 1, 3'b010, 3'b000, 3'b000, 1};
        tbl[15] = '{0, 1, 0, 3'b111, 3'b010, 3'b010, 0};
        tbl[16] = '{0, 1, 0, 3'b001, 3'b000, 3'b010, 0};
        tbl[17] = '{1, 1, 1, 3'b111, 3'b000, 3'b000, 0};
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].t, tbl[i].q, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d grant", i),  int'(grant),  int'(tbl[i].eg));
            chk($sformatf("vec%0d active", i), int'(active), int'(tbl[i].ea));
            chk($sformatf("vec%0d points", i), int'(points), tbl[i].ep);
        end

        // Grant coinciding with a refill wrap at saturation keeps points at MP.
        for (int k = 1; k <= 15; k++) begin
            step(0, 1, 1, 3'b000, "fill");
            step(0, 1, 0, 3'b000, "fill");
        end
        chk("fill points", int'(points), 3);
        step(0, 1, 1, 3'b100, "grant_wrap");
        chk("grant_wrap grant",  int'(grant),  4);
        chk("grant_wrap points", int'(points), 3);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bit         r;
            bit         e;
            bit         t;
            logic [2:0] q;
            r = ($urandom_range(63) == 0);
            e = ($urandom_range(15) != 0);
            t = $urandom_range(1);
            q = ($urandom_range(2) == 0) ? 3'($urandom_range(7)) : 3'b000;
            step(r, e, t, q, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
